// File: rtl/graph_aggregator_if.sv
// Stream bundle for graph_aggregator: node feature beats in, aggregated rows out.
// master = upstream/downstream environment, slave = the aggregator itself.
interface graph_aggregator_if #(
    parameter int NUM_NODES = 4,
    parameter int NUM_FEAT  = 4,
    parameter int IN_W      = 5,
    parameter int OUT_W     = 7
);
    localparam int NIDX_W = ($clog2(NUM_NODES) > 1) ? $clog2(NUM_NODES) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_FEAT*IN_W-1:0]  in_feat;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_FEAT*OUT_W-1:0] out_feat;
    logic [NIDX_W-1:0]         out_node;
    logic                      out_last;
    logic                      out_ovf;

    modport master (
        output in_valid, in_feat, out_ready,
        input  in_ready, out_valid, out_feat, out_node, out_last, out_ovf
    );

    modport slave (
        input  in_valid, in_feat, out_ready,
        output in_ready, out_valid, out_feat, out_node, out_last, out_ovf
    );
endinterface

// File: rtl/graph_aggregator.sv
// Streaming GNN neighbour aggregation: buffers one frame of node feature
// vectors, then emits per node the sum of the neighbours selected by a
// run-time adjacency mask, reduced to OUT_W by saturation or wrap.
module graph_aggregator #(
    parameter int NUM_NODES = 4,
    parameter int NUM_FEAT  = 4,
    parameter int IN_W      = 5,
    parameter int OUT_W     = 7,
    localparam int NIDX_W   = ($clog2(NUM_NODES) > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    graph_aggregator_if.slave    bus,
    input  logic                 adj_we,
    input  logic [NIDX_W-1:0]    adj_row,
    input  logic [NUM_NODES-1:0] adj_data,
    input  logic                 sat_en,
    output logic                 busy
);
    // Accumulator wide enough for NUM_NODES signed IN_W terms.
    localparam int ACC_W   = IN_W + NIDX_W + 1;
    localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_W - 1));
    localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      next_state_s;
    logic [NIDX_W-1:0]           cnt_r;
    logic signed [IN_W-1:0]      buf_r [NUM_NODES][NUM_FEAT];
    logic [NUM_NODES-1:0]        adj_r [NUM_NODES];

    logic                        out_valid_r;
    logic [NUM_FEAT*OUT_W-1:0]   out_feat_r;
    logic [NIDX_W-1:0]           out_node_r;
    logic                        out_last_r;
    logic                        out_ovf_r;

    logic                        in_fire_s;
    logic                        out_fire_s;
    logic                        load_row_s;
    logic                        clr_valid_s;
    logic [NIDX_W-1:0]           row_sel_s;
    logic [NUM_FEAT*OUT_W-1:0]   row_feat_s;
    logic                        row_ovf_s;

    // Sign-extend one buffered feature to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_fn(input logic signed [IN_W-1:0] x);
        sext_fn = {{(ACC_W - IN_W){x[IN_W-1]}}, x};
    endfunction

    // True when a full-precision sum does not fit the signed OUT_W range.
    function automatic logic ovf_fn(input logic signed [ACC_W-1:0] acc);
        ovf_fn = (int'(acc) > OUT_MAX) || (int'(acc) < OUT_MIN);
    endfunction

    // Reduce a full-precision sum to OUT_W: clamp when sat is set, else keep low bits.
    function automatic logic [OUT_W-1:0] reduce_fn(input logic signed [ACC_W-1:0] acc,
                                                   input logic sat);
        if (sat && (int'(acc) > OUT_MAX)) begin
            reduce_fn = OUT_W'(OUT_MAX);
        end else if (sat && (int'(acc) < OUT_MIN)) begin
            reduce_fn = OUT_W'(OUT_MIN);
        end else begin
            reduce_fn = OUT_W'(int'(acc));
        end
    endfunction

    assign in_fire_s  = (state_r == ST_LOAD) && bus.in_valid;
    assign out_fire_s = out_valid_r && bus.out_ready;

    assign bus.in_ready  = (state_r == ST_LOAD);
    assign bus.out_valid = out_valid_r;
    assign bus.out_feat  = out_feat_r;
    assign bus.out_node  = out_node_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_ovf   = out_ovf_r;
    assign busy          = (state_r != ST_LOAD) || (cnt_r != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and row-load control.
    always_comb begin
        next_state_s = state_r;
        load_row_s   = 1'b0;
        clr_valid_s  = 1'b0;
        row_sel_s    = '0;
        case (state_r)
            ST_LOAD: begin
                if (in_fire_s && (cnt_r == LAST_IDX)) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_CALC: begin
                next_state_s = ST_DRAIN;
                load_row_s   = 1'b1;
                row_sel_s    = '0;
            end
            ST_DRAIN: begin
                if (out_fire_s && out_last_r) begin
                    next_state_s = ST_LOAD;
                    clr_valid_s  = 1'b1;
                end else if (out_fire_s) begin
                    load_row_s   = 1'b1;
                    row_sel_s    = out_node_r + NIDX_W'(1);
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_LOAD;
            end
        endcase
    end

    // Beat counter: index of the next node to capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (in_fire_s) begin
            cnt_r <= (cnt_r == LAST_IDX) ? '0 : (cnt_r + NIDX_W'(1));
        end
    end

    // Feature buffer; every entry is overwritten each frame so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            for (int f = 0; f < NUM_FEAT; f++) begin
                buf_r[cnt_r][f] <= bus.in_feat[f*IN_W +: IN_W];
            end
        end
    end

    // Adjacency mask: default excludes the mirror node; writable only while loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                for (int j = 0; j < NUM_NODES; j++) begin
                    adj_r[i][j] <= (j != (NUM_NODES - 1 - i));
                end
            end
        end else if ((state_r == ST_LOAD) && adj_we && (int'(adj_row) < NUM_NODES)) begin
            adj_r[adj_row] <= adj_data;
        end
    end

    // Aggregate the selected row across all features.
    always_comb begin
        logic signed [ACC_W-1:0] acc_v;
        acc_v      = '0;
        row_feat_s = '0;
        row_ovf_s  = 1'b0;
        for (int f = 0; f < NUM_FEAT; f++) begin
            acc_v = '0;
            for (int j = 0; j < NUM_NODES; j++) begin
                if (adj_r[row_sel_s][j]) begin
                    acc_v = acc_v + sext_fn(buf_r[j][f]);
                end else begin
                    acc_v = acc_v;
                end
            end
            row_ovf_s = row_ovf_s | ovf_fn(acc_v);
            row_feat_s[f*OUT_W +: OUT_W] = reduce_fn(acc_v, sat_en);
        end
    end

    // Output registers: load a row on CALC or on a non-final handshake, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_feat_r  <= '0;
            out_node_r  <= '0;
            out_last_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else if (load_row_s) begin
            out_valid_r <= 1'b1;
            out_feat_r  <= row_feat_s;
            out_node_r  <= row_sel_s;
            out_last_r  <= (row_sel_s == LAST_IDX);
            out_ovf_r   <= row_ovf_s;
        end else if (clr_valid_s) begin
            out_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_graph_aggregator.sv
// Self-checking bench for graph_aggregator. Two instances (OUT_W = 7 and 6)
// share the same stimulus; a behavioural model of the frame computes sums.
module tb_graph_aggregator;
    localparam int N  = 4;
    localparam int F  = 4;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid;
    logic [F*IW-1:0]   in_feat;
    logic              out_ready;
    logic              adj_we;
    logic [1:0]        adj_row;
    logic [N-1:0]      adj_data;
    logic              sat_en;
    logic              busy7;
    logic              busy6;

    graph_aggregator_if #(.NUM_NODES(N), .NUM_FEAT(F), .IN_W(IW), .OUT_W(7)) ifc7 ();
    graph_aggregator_if #(.NUM_NODES(N), .NUM_FEAT(F), .IN_W(IW), .OUT_W(6)) ifc6 ();

    assign ifc7.in_valid  = in_valid;
    assign ifc7.in_feat   = in_feat;
    assign ifc7.out_ready = out_ready;
    assign ifc6.in_valid  = in_valid;
    assign ifc6.in_feat   = in_feat;
    assign ifc6.out_ready = out_ready;

    graph_aggregator #(.NUM_NODES(N), .NUM_FEAT(F), .IN_W(IW), .OUT_W(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .bus(ifc7), .adj_we(adj_we), .adj_row(adj_row),
        .adj_data(adj_data), .sat_en(sat_en), .busy(busy7)
    );
    graph_aggregator #(.NUM_NODES(N), .NUM_FEAT(F), .IN_W(IW), .OUT_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(ifc6), .adj_we(adj_we), .adj_row(adj_row),
        .adj_data(adj_data), .sat_en(sat_en), .busy(busy6)
    );

    int           checks = 0;
    int           errors = 0;
    int           feat_m [N][F];
    logic [N-1:0] adj_m [N];
    bit           use_const = 1'b0;
    int           const_lane [N];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void default_adj();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                adj_m[i][j] = (j != N - 1 - i);
    endfunction

    function automatic int row_sum(input int r, input int f);
        int s = 0;
        for (int j = 0; j < N; j++)
            if (adj_m[r][j]) s += feat_m[j][f];
        return s;
    endfunction

    // Mathematical reduction: clamp, or modular wrap into [lo, hi].
    function automatic int reduce_m(input int s, input int w, input bit sat);
        int lo   = -(1 << (w - 1));
        int hi   = (1 << (w - 1)) - 1;
        int span = 1 << w;
        int v;
        if (sat) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        v = (s - lo) % span;
        if (v < 0) v += span;
        return v + lo;
    endfunction

    function automatic bit ovf_m(input int s, input int w);
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    function automatic void ramp_feats();
        for (int n = 0; n < N; n++)
            for (int f = 0; f < F; f++)
                feat_m[n][f] = n + 1;
    endfunction

    function automatic void const_feats(input int v);
        for (int n = 0; n < N; n++)
            for (int f = 0; f < F; f++)
                feat_m[n][f] = v;
    endfunction

    function automatic void rand_feats();
        for (int n = 0; n < N; n++)
            for (int f = 0; f < F; f++)
                feat_m[n][f] = int'($urandom_range(0, 31)) - 16;
    endfunction

    task automatic check_reset();
        chk("rst in_ready", ifc7.in_ready, 1);
        chk("rst out_valid", ifc7.out_valid, 0);
        chk("rst out_feat", ifc7.out_feat, 0);
        chk("rst out_node", ifc7.out_node, 0);
        chk("rst out_last", ifc7.out_last, 0);
        chk("rst out_ovf", ifc7.out_ovf, 0);
        chk("rst busy", busy7, 0);
        chk("rst6 out_valid", ifc6.out_valid, 0);
        chk("rst6 out_feat", ifc6.out_feat, 0);
        chk("rst6 busy", busy6, 0);
    endtask

    task automatic check_row(input int r);
        bit o7 = 1'b0;
        bit o6 = 1'b0;
        int s;
        chk($sformatf("valid r%0d", r), ifc7.out_valid, 1);
        chk($sformatf("valid6 r%0d", r), ifc6.out_valid, 1);
        chk($sformatf("node r%0d", r), ifc7.out_node, r);
        chk($sformatf("last r%0d", r), ifc7.out_last, (r == N - 1));
        chk($sformatf("last6 r%0d", r), ifc6.out_last, (r == N - 1));
        for (int f = 0; f < F; f++) begin
            s = row_sum(r, f);
            chk($sformatf("feat7 r%0d f%0d", r, f), $signed(ifc7.out_feat[f*7 +: 7]),
                reduce_m(s, 7, sat_en));
            chk($sformatf("feat6 r%0d f%0d", r, f), $signed(ifc6.out_feat[f*6 +: 6]),
                reduce_m(s, 6, sat_en));
            o7 |= ovf_m(s, 7);
            o6 |= ovf_m(s, 6);
        end
        if (use_const)
            chk($sformatf("const r%0d", r), $signed(ifc7.out_feat[6:0]), const_lane[r]);
        chk($sformatf("ovf7 r%0d", r), ifc7.out_ovf, o7);
        chk($sformatf("ovf6 r%0d", r), ifc6.out_ovf, o6);
        chk($sformatf("in_ready r%0d", r), ifc7.in_ready, 0);
        chk($sformatf("busy r%0d", r), busy7, 1);
    endtask

    task automatic adj_write(input int row, input logic [N-1:0] d);
        adj_we   = 1'b1;
        adj_row  = 2'(row);
        adj_data = d;
        @(posedge clk); #1;
        adj_we   = 1'b0;
        adj_m[row] = d;
    endtask

    // Send one frame; optional gap pattern 1,0,0,1,1,0,1 and optional mask write on the final beat.
    task automatic send_frame(input bit gaps, input bit fw_en, input int fw_row,
                              input logic [N-1:0] fw_data);
        logic [6:0] pat = 7'b1011001;
        int n = 0;
        int k = 0;
        while (n < N) begin
            in_valid = (gaps && k < 7) ? pat[k] : 1'b1;
            for (int f = 0; f < F; f++)
                in_feat[f*IW +: IW] = in_valid ? IW'(feat_m[n][f]) : IW'($urandom);
            adj_we = 1'b0;
            if (in_valid && n == N - 1 && fw_en) begin
                adj_we   = 1'b1;
                adj_row  = 2'(fw_row);
                adj_data = fw_data;
            end
            if (in_valid) chk($sformatf("in_ready beat%0d", n), ifc7.in_ready, 1);
            @(posedge clk); #1;
            if (in_valid) begin
                if (adj_we) adj_m[fw_row] = fw_data;
                n++;
            end
            k++;
        end
        in_valid = 1'b0;
        adj_we   = 1'b0;
        chk("lat E+1 valid", ifc7.out_valid, 0);
        chk("lat E+1 in_ready", ifc7.in_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic drain_frame(input int stall_row, input int stall_len, input bit rnd,
                               input bit drain_wr, input int rst_row);
        int st;
        for (int r = 0; r < N; r++) begin
            if (r == rst_row) begin
                rst_n = 1'b0;
                #2;
                check_reset();
                @(negedge clk);
                rst_n = 1'b1;
                default_adj();
                @(posedge clk); #1;
                check_reset();
                return;
            end
            st = (r == stall_row) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            check_row(r);
            if (st > 0) begin
                out_ready = 1'b0;
                for (int c = 0; c < st; c++) begin
                    @(posedge clk); #1;
                    check_row(r);
                end
            end
            out_ready = 1'b1;
            if (drain_wr && r == 1) begin
                adj_we   = 1'b1;
                adj_row  = 2'd0;
                adj_data = '0;
            end
            @(posedge clk); #1;
            adj_we = 1'b0;
        end
        chk("end out_valid", ifc7.out_valid, 0);
        chk("end busy", busy7, 0);
        chk("end in_ready", ifc7.in_ready, 1);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_feat   = '0;
        out_ready = 1'b1;
        adj_we    = 1'b0;
        adj_row   = 2'd0;
        adj_data  = '0;
        sat_en    = 1'b1;
        const_lane = '{6, 7, 8, 9};
        default_adj();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Default mask, ramp features: 6, 7, 8, 9.
        ramp_feats();
        use_const = 1'b1;
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);
        // Same frame, row 1 stalled for 3 cycles.
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(1, 3, 1'b0, 1'b0, -1);
        // Same frame with input gaps.
        send_frame(1'b1, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);
        use_const = 1'b0;

        // Full mask, overflow cases.
        for (int r = 0; r < N; r++) adj_write(r, 4'b1111);
        const_feats(15);
        sat_en = 1'b1;
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);
        sat_en = 1'b0;
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);
        const_feats(-16);
        sat_en = 1'b1;
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);

        // Self-only row 2; a write issued during DRAIN must be ignored.
        adj_write(2, 4'b0100);
        rand_feats();
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b1, -1);
        rand_feats();
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);
        // Empty row 0 written in LOAD.
        adj_write(0, 4'b0000);
        rand_feats();
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);

        // Reset during DRAIN row 2, then default mask is back.
        adj_write(1, 4'b1000);
        ramp_feats();
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, 2);
        use_const = 1'b1;
        send_frame(1'b0, 1'b0, 0, '0);
        drain_frame(-1, 0, 1'b0, 1'b0, -1);
        use_const = 1'b0;

        // Randomised frames: masks, final-beat writes, saturation mode, gaps, stalls.
        for (int t = 0; t < 25; t++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++)
                adj_write(int'($urandom_range(0, N - 1)), N'($urandom));
            sat_en = 1'($urandom);
            rand_feats();
            send_frame(1'($urandom), 1'($urandom), int'($urandom_range(0, N - 1)), N'($urandom));
            drain_frame(-1, 0, 1'b1, 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
